joy_serial_scan: RTL and testbench

//  Scans two DB9 joysticks (Sega 3-button capable) through an external 16-bit
//  74HC165 parallel-in/serial-out chain, drives the pad SELECT line, debounces
//  the results and delivers active-high joy1/joy2 bytes to the main core.

---
 rtl/joy_serial_scan_if.sv | 26 ++
 rtl/joy_serial_scan.sv | 148 ++++++++++++++
 tb/tb_joy_serial_scan.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/joy_serial_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : joy_serial_scan_if
// Brief   : Joystick scanner bus: 74HC165 chain pins plus decoded pad bytes.
// Revision: 1.0
// ============================================================================
interface joy_serial_scan_if;
   logic       joyCk;
   logic       joyLd;
   logic       joyS;
   logic       joyD;
   logic [7:0] joy1;
   logic [7:0] joy2;
   logic       strb;

   modport master (
      output joyCk, joyLd, joyS, joy1, joy2, strb,
      input  joyD
   );

   modport slave (
      input  joyCk, joyLd, joyS, joy1, joy2, strb,
      output joyD
   );
endinterface
`default_nettype wire

// File: rtl/joy_serial_scan.sv
`default_nettype none
// ============================================================================
// Module  : joy_serial_scan
// Brief   : Two-phase Sega/DB9 pad scanner over a 16-bit 74HC165 chain with
//           two-frame debounce of the active-high joy1/joy2 bytes.
// Revision: 1.0
// ============================================================================
module joy_serial_scan #(
   parameter int CEDIV  = 8,
   parameter int SETTLE = 4,
   parameter int GAP    = 2000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   joy_serial_scan_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SHIFT  = 3'd2,
      S_WAIT   = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   state_t      r_state;
   logic [7:0]  r_div;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic        r_half;
   logic        r_phase;
   logic [15:0] r_shift;
   logic [11:0] r_raw1;
   logic [15:0] r_prev;
   logic        r_ck;
   logic        r_ld;
   logic        r_s;
   logic        r_strb;
   logic [7:0]  r_joy1;
   logic [7:0]  r_joy2;

   logic        w_tick;
   logic [15:0] w_frame;

   assign w_tick = ce && (r_div == 8'(CEDIV - 1));

   // Phase-0 raw bits are still in r_shift at COMMIT; phase-1 keeps only the
   // six meaningful bits per port (up,down,left,right,pin6,pin9).
   assign w_frame = ~{r_shift[13], r_shift[12], r_raw1[11], r_raw1[10],
                      r_raw1[6],   r_raw1[7],   r_raw1[8],   r_raw1[9],
                      r_shift[5],  r_shift[4],  r_raw1[5],   r_raw1[4],
                      r_raw1[0],   r_raw1[1],   r_raw1[2],   r_raw1[3]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_div   <= 8'd0;
         r_cnt   <= 16'd0;
         r_bit   <= 4'd0;
         r_half  <= 1'b0;
         r_phase <= 1'b1;
         r_shift <= 16'hFFFF;
         r_raw1  <= 12'hFFF;
         r_prev  <= 16'h0000;
         r_ck    <= 1'b0;
         r_ld    <= 1'b1;
         r_s     <= 1'b1;
         r_strb  <= 1'b0;
         r_joy1  <= 8'h00;
         r_joy2  <= 8'h00;
      end else begin
         r_strb <= 1'b0;
         if (ce) begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            case (r_state)
               S_IDLE: if (w_tick) begin
                  if (r_cnt == 16'(GAP - 1)) begin
                     r_cnt   <= 16'd0;
                     r_phase <= 1'b1;
                     r_ld    <= 1'b0;
                     r_state <= S_LOAD;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               S_LOAD: if (w_tick) begin
                  r_ld    <= 1'b1;
                  r_bit   <= 4'd0;
                  r_half  <= 1'b0;
                  r_state <= S_SHIFT;
               end
               S_SHIFT: if (w_tick) begin
                  if (!r_half) begin
                     // First bit out of the chain ends up in bit 0.
                     r_shift <= {bus.joyD, r_shift[15:1]};
                     r_ck    <= 1'b1;
                     r_half  <= 1'b1;
                  end else begin
                     r_ck   <= 1'b0;
                     r_half <= 1'b0;
                     r_bit  <= r_bit + 4'd1;
                     if (r_bit == 4'd15) begin
                        if (r_phase) begin
                           r_raw1  <= {r_shift[13:8], r_shift[5:0]};
                           r_s     <= 1'b0;
                           r_state <= S_WAIT;
                        end else begin
                           r_state <= S_COMMIT;
                        end
                     end
                  end
               end
               S_WAIT: if (w_tick) begin
                  if (r_cnt == 16'(SETTLE - 1)) begin
                     r_cnt   <= 16'd0;
                     r_phase <= 1'b0;
                     r_ld    <= 1'b0;
                     r_state <= S_LOAD;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               S_COMMIT: begin
                  r_s    <= 1'b1;
                  r_prev <= w_frame;
                  if (w_frame == r_prev && w_frame != {r_joy2, r_joy1}) begin
                     r_joy1 <= w_frame[7:0];
                     r_joy2 <= w_frame[15:8];
                     r_strb <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.joyCk = r_ck;
   assign bus.joyLd = r_ld;
   assign bus.joyS  = r_s;
   assign bus.joy1  = r_joy1;
   assign bus.joy2  = r_joy2;
   assign bus.strb  = r_strb;

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_joy_serial_scan
// Brief   : Random-ce bench with 165-chain/Sega pad model and timeline model.
// Revision: 1.0
// ============================================================================
module tb_joy_serial_scan;

   localparam int CEDIV  = 2;
   localparam int SETTLE = 3;
   localparam int GAP    = 10;
   localparam int L0     = GAP + 33 + SETTLE;   // tick index of phase-0 load
   localparam int P      = L0 + 33;             // ticks per frame

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   joy_serial_scan_if bus();

   joy_serial_scan #(.CEDIV(CEDIV), .SETTLE(SETTLE), .GAP(GAP)) dut (
      .clock (clk),
      .reset (rst),
      .ce    (ce),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Pads: {start,A,C,B,up,down,left,right}, 1 = pressed.
   logic [7:0]  pad1  = 8'h00;
   logic [7:0]  pad2  = 8'h00;
   logic        nopad = 1'b0;
   logic [15:0] chain = 16'hFFFF;
   logic        ck_q  = 1'b0;

   // Sega 3-button pad: SELECT low forces left/right low.
   function automatic logic [7:0] sega(input logic [7:0] pad, input logic sel);
      logic [7:0] r;
      r[0]   = ~pad[3];
      r[1]   = ~pad[2];
      r[2]   = sel ? ~pad[1] : 1'b0;
      r[3]   = sel ? ~pad[0] : 1'b0;
      r[4]   = sel ? ~pad[4] : ~pad[6];
      r[5]   = sel ? ~pad[5] : ~pad[7];
      r[7:6] = 2'b11;
      return r;
   endfunction

   always @(posedge clk) begin
      if (!bus.joyLd)
         chain <= {sega(pad2, bus.joyS), sega(pad1, bus.joyS)};
      else if (bus.joyCk && !ck_q)
         chain <= {1'b1, chain[15:1]};
      ck_q <= bus.joyCk;
   end
   assign bus.joyD = nopad ? 1'b1 : chain[0];

   // Reference: global ce count fixes the whole line timeline arithmetically.
   int          c       = 0;
   int          commits = 0;
   logic [15:0] m_prev  = 16'h0000;
   logic [15:0] m_f;
   logic [7:0]  m_j1    = 8'h00;
   logic [7:0]  m_j2    = 8'h00;
   logic        m_strb  = 1'b0;

   function automatic int pos(input int cc);
      int t = cc / CEDIV;
      return (t == 0) ? 0 : (t - 1) % P + 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c = 0; m_prev = 16'h0000; m_j1 = 8'h00; m_j2 = 8'h00; m_strb = 1'b0;
      end else begin
         m_strb = 1'b0;
         if (ce) begin
            c = c + 1;
            if (c % CEDIV == 1 && c / CEDIV > 0 && (c / CEDIV) % P == 0) begin
               m_f = nopad ? 16'h0000 : {pad2, pad1};
               if (m_f == m_prev && m_f != {m_j2, m_j1}) begin
                  m_j1 = m_f[7:0]; m_j2 = m_f[15:8]; m_strb = 1'b1;
               end
               m_prev  = m_f;
               commits = commits + 1;
            end
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         int k;
         logic eld, eck, es;
         k   = pos(c);
         eld = 1'b1; eck = 1'b0; es = 1'b1;
         if (k > 0) begin
            eld = !(k == GAP || k == L0);
            eck = (k >= GAP + 2 && k <= GAP + 33 && (k - GAP) % 2 == 0) ||
                  (k >= L0 + 2  && k <= L0 + 33  && (k - L0) % 2 == 0);
            es  = !((k >= GAP + 33 && k < P) || (k == P && c % CEDIV == 0));
         end
         chk("joyLd", 16'(bus.joyLd), 16'(eld));
         chk("joyCk", 16'(bus.joyCk), 16'(eck));
         chk("joyS",  16'(bus.joyS),  16'(es));
         chk("joy1",  16'(bus.joy1),  16'(m_j1));
         chk("joy2",  16'(bus.joy2),  16'(m_j2));
         chk("strb",  16'(bus.strb),  16'(m_strb));
      end
   end

   int strb_seen = 0;
   always @(posedge clk) if (bus.strb === 1'b1) strb_seen++;

   logic ce_hold = 1'b0;
   int   ce_pct  = 75;
   initial forever begin
      @(negedge clk);
      ce = ce_hold ? 1'b0 : (int'($urandom_range(99)) < ce_pct);
   end

   task automatic wait_commits(input int n);
      int target = commits + n;
      int budget = 0;
      while (commits < target && budget < 4000) begin
         @(negedge clk);
         budget++;
      end
      chk("frame_timeout", 16'(commits >= target), 16'd1);
      @(negedge clk);
   endtask

   task automatic wait_in_shift();
      int budget = 0;
      while (!(pos(c) >= GAP + 4 && pos(c) <= GAP + 30) && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      chk("shift_timeout", 16'(budget < 2000), 16'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_joyCk"}, 16'(bus.joyCk), 16'd0);
      chk({tag, "_joyLd"}, 16'(bus.joyLd), 16'd1);
      chk({tag, "_joyS"},  16'(bus.joyS),  16'd1);
      chk({tag, "_joy1"},  16'(bus.joy1),  16'h00);
      chk({tag, "_joy2"},  16'(bus.joy2),  16'h00);
      chk({tag, "_strb"},  16'(bus.strb),  16'd0);
   endtask

   initial begin
      int s0;
      int budget;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      // pad1 up+B+Start, pad2 idle
      pad1 = 8'h98; pad2 = 8'h00;
      s0 = strb_seen;
      wait_commits(2);
      chk("t3_joy1", 16'(bus.joy1), 16'h98);
      chk("t3_joy2", 16'(bus.joy2), 16'h00);
      chk("t3_model", 16'(m_j1), 16'h98);
      chk("t3_strb", 16'(strb_seen - s0), 16'd1);
      s0 = strb_seen;
      wait_commits(2);
      chk("t3_nostrb", 16'(strb_seen - s0), 16'd0);

      // pad2 right+A+C
      pad2 = 8'h61;
      s0 = strb_seen;
      wait_commits(2);
      chk("t4_joy2", 16'(bus.joy2), 16'h61);
      chk("t4_joy1", 16'(bus.joy1), 16'h98);
      chk("t4_strb", 16'(strb_seen - s0), 16'd1);

      // alternating presses never settle
      s0 = strb_seen;
      for (int i = 0; i < 6; i++) begin
         pad1 = (i % 2 == 1) ? 8'h0F : 8'hF0;
         wait_commits(1);
      end
      chk("t5_joy1", 16'(bus.joy1), 16'h98);
      chk("t5_joy2", 16'(bus.joy2), 16'h61);
      chk("t5_strb", 16'(strb_seen - s0), 16'd0);

      // ce held low mid-scan
      pad1 = 8'h24;
      wait_in_shift();
      ce_hold = 1'b1;
      repeat (1000) @(negedge clk);
      ce_hold = 1'b0;
      wait_commits(2);
      chk("t6_joy1", 16'(bus.joy1), 16'h24);

      // random pads and ce density
      for (int i = 0; i < 10; i++) begin
         pad1   = 8'($urandom);
         pad2   = 8'($urandom);
         ce_pct = int'($urandom_range(100, 40));
         wait_commits(int'($urandom_range(3, 1)));
      end
      ce_pct = 75;

      // reset mid-SHIFT
      wait_in_shift();
      #2 rst = 1'b1;
      #1 chk_reset_vals("t1");
      @(negedge clk);
      rst = 1'b0;
      budget = 0;
      while (bus.joyLd === 1'b1 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      chk("t1_gap_ticks", 16'(c / CEDIV), 16'(GAP));
      wait_commits(2);
      chk("t1_joy1", 16'(bus.joy1), 16'(pad1));
      chk("t1_joy2", 16'(bus.joy2), 16'(pad2));

      // disconnected pads
      nopad = 1'b1;
      wait_commits(2);
      chk("nopad_joy1", 16'(bus.joy1), 16'h00);
      chk("nopad_joy2", 16'(bus.joy2), 16'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
